// File: rtl/dma_pkg.sv
// Shared types and width defaults for the scatter-gather DMA descriptor path.
// Holds the descriptor-port arbiter FSM encoding and grant-owner encoding.
package dma_pkg;

    localparam int DMA_ADDR_W   = 32;
    localparam int DMA_DATA_W   = 32;
    localparam int DMA_BCOUNT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_CMD  = 2'd1,
        RD_DATA = 2'd2,
        WR      = 2'd3
    } desc_arb_state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_UPD   = 1'b1
    } gnt_owner_t;

endpackage

// File: rtl/dma_rr_arb2.sv
// Two-requester round-robin picker; the last-grant flag moves only when a
// command is actually accepted by the master, not when it is merely granted.
import dma_pkg::*;

module dma_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_fetch_i,
    input  logic       req_upd_i,
    input  logic       accept_i,
    input  gnt_owner_t accept_owner_i,
    output logic       gnt_valid_o,
    output gnt_owner_t gnt_owner_o
);

    gnt_owner_t last_q;
    gnt_owner_t last_d;

    // Reset to the update owner so the fetch path wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= GNT_UPD;
        end else begin
            last_q <= last_d;
        end
    end

    always_comb begin
        last_d = last_q;
        if (accept_i) begin
            last_d = accept_owner_i;
        end
    end

    always_comb begin
        gnt_valid_o = req_fetch_i | req_upd_i;
        gnt_owner_o = GNT_FETCH;
        if (req_fetch_i && req_upd_i) begin
            gnt_owner_o = (last_q == GNT_FETCH) ? GNT_UPD : GNT_FETCH;
        end else if (req_upd_i) begin
            gnt_owner_o = GNT_UPD;
        end
    end

endmodule

// File: rtl/dma_desc_port_arb.sv
// Shares one AVMM descriptor-memory master between the fetch (burst read) and
// status-update (single write) paths; writes wait for all read beats.
import dma_pkg::*;

module dma_desc_port_arb #(
    parameter int ADDR_W   = DMA_ADDR_W,
    parameter int DATA_W   = DMA_DATA_W,
    parameter int BCOUNT_W = DMA_BCOUNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                fetch_read_i,
    input  logic [BCOUNT_W-1:0] fetch_bcount_i,
    input  logic [ADDR_W-1:0]   fetch_addr_i,
    output logic                fetch_waitrequest_o,
    output logic [DATA_W-1:0]   fetch_rddata_o,
    output logic                fetch_readdatavalid_o,
    input  logic                upd_wr_i,
    input  logic [DATA_W-1:0]   upd_data_i,
    input  logic [DATA_W/8-1:0] upd_be_i,
    input  logic [ADDR_W-1:0]   upd_addr_i,
    output logic                upd_wait_req_o,
    output logic                mst_read_o,
    output logic                mst_write_o,
    output logic [ADDR_W-1:0]   mst_addr_o,
    output logic [BCOUNT_W-1:0] mst_bcount_o,
    output logic [DATA_W-1:0]   mst_wrdata_o,
    output logic [DATA_W/8-1:0] mst_be_o,
    input  logic                mst_waitrequest_i,
    input  logic [DATA_W-1:0]   mst_rddata_i,
    input  logic                mst_readdatavalid_i,
    output logic                spurious_rdv_o
);

    desc_arb_state_t     state_q, state_d;
    logic [BCOUNT_W-1:0] beats_q, beats_d;
    logic                spur_q, spur_d;
    logic                rd_acc, wr_acc;
    logic                gnt_valid;
    gnt_owner_t          gnt_owner;

    assign rd_acc = (state_q == RD_CMD) && !mst_waitrequest_i;
    assign wr_acc = (state_q == WR) && !mst_waitrequest_i;

    dma_rr_arb2 u_rr (
        .clk            (clk),
        .reset          (reset),
        .req_fetch_i    (fetch_read_i),
        .req_upd_i      (upd_wr_i),
        .accept_i       (rd_acc | wr_acc),
        .accept_owner_i (wr_acc ? GNT_UPD : GNT_FETCH),
        .gnt_valid_o    (gnt_valid),
        .gnt_owner_o    (gnt_owner)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            beats_q <= '0;
            spur_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beats_q <= beats_d;
            spur_q  <= spur_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d = (gnt_owner == GNT_FETCH) ? RD_CMD : WR;
                end
            end
            RD_CMD: begin
                if (rd_acc) begin
                    state_d = (fetch_bcount_i == '0) ? IDLE : RD_DATA;
                end
            end
            RD_DATA: begin
                if (mst_readdatavalid_i && beats_q == BCOUNT_W'(1)) begin
                    state_d = IDLE;
                end
            end
            WR: begin
                if (wr_acc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Beats arriving outside RD_DATA are flagged but never counted.
    always_comb begin
        beats_d = beats_q;
        spur_d  = spur_q;
        if (rd_acc) begin
            beats_d = fetch_bcount_i;
        end else if (state_q == RD_DATA && mst_readdatavalid_i) begin
            beats_d = beats_q - BCOUNT_W'(1);
        end
        if (mst_readdatavalid_i && state_q != RD_DATA) begin
            spur_d = 1'b1;
        end
    end

    always_comb begin
        mst_read_o            = 1'b0;
        mst_write_o           = 1'b0;
        mst_addr_o            = '0;
        mst_bcount_o          = '0;
        mst_wrdata_o          = '0;
        mst_be_o              = '0;
        fetch_waitrequest_o   = 1'b1;
        upd_wait_req_o        = 1'b1;
        fetch_rddata_o        = '0;
        fetch_readdatavalid_o = 1'b0;
        unique case (state_q)
            RD_CMD: begin
                mst_read_o          = 1'b1;
                mst_addr_o          = fetch_addr_i;
                mst_bcount_o        = fetch_bcount_i;
                fetch_waitrequest_o = mst_waitrequest_i;
            end
            RD_DATA: begin
                fetch_rddata_o        = mst_rddata_i;
                fetch_readdatavalid_o = mst_readdatavalid_i;
            end
            WR: begin
                mst_write_o    = 1'b1;
                mst_addr_o     = upd_addr_i;
                mst_wrdata_o   = upd_data_i;
                mst_be_o       = upd_be_i;
                upd_wait_req_o = mst_waitrequest_i;
            end
            default: ;
        endcase
    end

    assign spurious_rdv_o = spur_q;

endmodule
